swap_engine: RTL
================

// Module: swap_engine
// PURPOSE
//   Iterative multi-round tag-segment swap scrambler for voting records. Each round exchanges an
//   s-bit, wrap-around segment between two TAG_SIZE blocks of the record; the block, offset and
//   length come from that round's slice of the secret key. One round runs per clock.
//   Valid/ready on both sides; sits between record intake and the storage/commit stage.
// PARAMETERS
//   TAG_SIZE     4   bits per block
//   RECORD_SIZE  16  record width; integer multiple of TAG_SIZE
//   ROUNDS       2   swap rounds per record (>=1)
//   derived: NB=RECORD_SIZE/TAG_SIZE; CB=$clog2(NB); CT=$clog2(TAG_SIZE); SW=CT+1;
//            RKW=2*CB+2*CT+SW; KEY_W=ROUNDS*RKW; RCW=$clog2(ROUNDS+1)
// PORTS
//   clk          in   1            clock, all state on rising edge
//   reset        in   1            synchronous, active-high
//   i_valid      in   1            input record/key valid
//   i_ready      out  1            engine can accept (IDLE only)
//   i_record     in   RECORD_SIZE  plaintext/scrambled record
//   secret_key   in   KEY_W        round r key = secret_key[r*RKW +: RKW]
//   i_decrypt    in   1            only with SWAP_ENGINE_DECRYPT_EN; 1 = apply rounds in reverse
//   o_valid      out  1            result valid; held until o_ready
//   o_ready      in   1            downstream accepts
//   o_record     out  RECORD_SIZE  result record
//   o_busy       out  1            1 in RUN or DONE
// BEHAVIOUR
//   Reset: state IDLE; o_valid=0, o_busy=0, o_record=0, i_ready=1, round counter=0. Reset wins over
//     every other event; reset mid-RUN/DONE discards the record, no output produced.
//   Round key (LSB first): bx[CB-1:0], by[2CB-1:CB], px[+CT], py[+CT], s[+SW].
//   Round op: seg1[i]=blk[bx][(px+i)%TAG_SIZE], seg2[i]=blk[by][(py+i)%TAG_SIZE], i<min(s,TAG_SIZE);
//     both read from the pre-round record, then exchanged; all other bits untouched.
//     px,py taken mod TAG_SIZE. s>TAG_SIZE clamps to TAG_SIZE; s=0 is identity.
//     bx==by, or bx/by >= NB -> identity round. Every round is an involution.
//   FSM IDLE -> RUN -> DONE -> IDLE:
//     IDLE: i_ready=1. i_valid&i_ready: latch i_record, full secret_key (and i_decrypt); cnt=0; -> RUN.
//     RUN: each edge applies round idx (fwd: cnt; decrypt: ROUNDS-1-cnt); cnt++; after round
//       ROUNDS-1 -> DONE. Inputs ignored, key changes on secret_key have no effect.
//     DONE: o_valid=1, o_record stable. o_valid&o_ready -> IDLE (i_ready=1 next cycle).
//   Latency: accept on edge t -> o_valid high from edge t+ROUNDS; throughput 1 per ROUNDS+2 cycles min.
//   o_record shows working register at all times; only meaningful while o_valid=1.
//   No accept while o_valid pending; no combinational path i_valid->i_ready or o_ready->i_ready.
// CONFIGURATION
//   SWAP_ENGINE_DECRYPT_EN defined: i_decrypt port present, latched at accept; 1 reverses round
//     order so decrypt(encrypt(x,k),k)==x. Undefined: port absent, rounds always 0..ROUNDS-1.
// TESTING (TAG_SIZE=4, RECORD_SIZE=16, ROUNDS=2, RKW=11, KEY_W=22)
//   Full block swap: rec=16'h00F0, key=22'h000404 (bx0,by1,s4; round1 s0) -> o_record=16'h000F,
//     o_valid exactly 2 edges after accept.
//   Partial: rec=16'h000F, key=22'h000228 (bx0,by2,px2,s2) -> 16'h0303.
//   Wrap-around: rec=16'h0009, key=22'h000234 (bx0,by1,px3,s2) -> 16'h0030.
//   Identity: bx==by or s=0 in both rounds, rec=16'hBEEF -> 16'hBEEF; s=7 behaves as s=4.
//   Backpressure/reset: hold o_ready=0 10 cycles -> o_valid,o_record stable, i_ready=0; assert reset
//     mid-RUN -> next cycle o_valid=0, i_ready=1, o_record=0, no output for that record.
//   DECRYPT_EN: encrypt random rec with two non-trivial rounds, feed result with i_decrypt=1 and
//     same key -> original rec; 1000 random pairs round-trip.

Source files
------------

// File: rtl/swap_engine.sv
// Iterative tag-segment swap scrambler: one key-driven segment exchange between two blocks per clock.
// Optional build macro SWAP_ENGINE_DECRYPT_EN adds i_decrypt, which applies the rounds in reverse order.
module swap_engine #(
   parameter int TAG_SIZE    = 4,
   parameter int RECORD_SIZE = 16,
   parameter int ROUNDS      = 2,
   localparam int NB    = RECORD_SIZE / TAG_SIZE,
   localparam int CB    = $clog2(NB),
   localparam int CT    = $clog2(TAG_SIZE),
   localparam int SW    = CT + 1,
   localparam int RKW   = 2*CB + 2*CT + SW,
   localparam int KEY_W = ROUNDS * RKW,
   localparam int RCW   = $clog2(ROUNDS + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [RECORD_SIZE-1:0] i_record,
   input  logic [KEY_W-1:0]       secret_key,
`ifdef SWAP_ENGINE_DECRYPT_EN
   input  logic                   i_decrypt,
`endif
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [RECORD_SIZE-1:0] o_record,
   output logic                   o_busy
);

   localparam int IW = $clog2(RECORD_SIZE);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic [RCW-1:0]       cnt;
   logic [RCW-1:0]       ridx;
   logic [KEY_W-1:0]     key_q;
   logic [RKW-1:0]       rkey;
   logic [RECORD_SIZE-1:0] next_rec;

   // Both segments are read from the pre-round record, so the exchange is a pure permutation.
   function automatic logic [RECORD_SIZE-1:0] apply_round(
      input logic [RECORD_SIZE-1:0] rec,
      input logic [RKW-1:0]         rk
   );
      logic [CB-1:0]          bx;
      logic [CB-1:0]          by;
      logic [CT-1:0]          px;
      logic [CT-1:0]          py;
      logic [SW-1:0]          s;
      logic [RECORD_SIZE-1:0] res;
      int                     len;
      int                     ia;
      int                     ib;
      bx  = rk[CB-1:0];
      by  = rk[2*CB-1:CB];
      px  = rk[2*CB +: CT];
      py  = rk[2*CB+CT +: CT];
      s   = rk[2*CB+2*CT +: SW];
      len = (int'(s) > TAG_SIZE) ? TAG_SIZE : int'(s);
      res = rec;
      if (bx != by && int'(bx) < NB && int'(by) < NB) begin
         for (int i = 0; i < TAG_SIZE; i++) begin
            if (i < len) begin
               ia = int'(bx) * TAG_SIZE + (int'(px) + i) % TAG_SIZE;
               ib = int'(by) * TAG_SIZE + (int'(py) + i) % TAG_SIZE;
               res[IW'(ia)] = rec[IW'(ib)];
               res[IW'(ib)] = rec[IW'(ia)];
            end
         end
      end
      return res;
   endfunction

`ifdef SWAP_ENGINE_DECRYPT_EN
   logic dec_q;

   always_ff @(posedge clk) begin
      if (state == IDLE && i_valid) dec_q <= i_decrypt;
   end

   always_comb begin
      ridx = dec_q ? (RCW'(ROUNDS - 1) - cnt) : cnt;
   end
`else
   always_comb begin
      ridx = cnt;
   end
`endif

   always_comb begin
      rkey = '0;
      for (int r = 0; r < ROUNDS; r++) begin
         if (RCW'(r) == ridx) rkey = key_q[r*RKW +: RKW];
      end
      next_rec = apply_round(o_record, rkey);
   end

   // The key is captured once at accept; later changes on secret_key cannot reach the rounds.
   always_ff @(posedge clk) begin
      if (state == IDLE && i_valid) key_q <= secret_key;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         i_ready  <= 1'b1;
         o_valid  <= 1'b0;
         o_busy   <= 1'b0;
         o_record <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  o_record <= i_record;
                  cnt      <= '0;
                  i_ready  <= 1'b0;
                  o_busy   <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               o_record <= next_rec;
               cnt      <= cnt + RCW'(1);
               if (cnt == RCW'(ROUNDS - 1)) begin
                  o_valid <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (o_ready) begin
                  o_valid <= 1'b0;
                  o_busy  <= 1'b0;
                  i_ready <= 1'b1;
                  cnt     <= '0;
                  state   <= IDLE;
               end
            end
            default: begin
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
               i_ready <= 1'b1;
               cnt     <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
